// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver: shared prescaled period counter, double-buffered duty registers.
// Define PWM_BREATHE_EN to add per-channel breathing (triangle ramp up to the shadow value).
module pwm_led_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned PRESC = 1,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             duty_we,
  input  logic [SELW-1:0]  duty_sel,
  input  logic [WIDTH-1:0] duty_wdata,
  input  logic [CH-1:0]    breathe_en,
  output logic [CH-1:0]    led,
  output logic             period_start
);

  localparam int unsigned      PreW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(PRESC - 1);
  // Last counter value is 2**WIDTH-2, so a full-scale duty keeps the LED on for the whole period.
  localparam logic [WIDTH-1:0] CntMax = ~WIDTH'(1);

  logic [PreW-1:0]          pre_q, pre_d;
  logic [WIDTH-1:0]         cnt_q, cnt_d;
  logic [CH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CH-1:0][WIDTH-1:0] active_q, active_d;
  logic [CH-1:0]            led_q, led_d;
  logic                     period_start_q, period_start_d;
  logic                     step, boundary;

  // Shared timebase.
  always_comb begin
    step           = (pre_q == PreMax);
    boundary       = step && (cnt_q == CntMax);
    pre_d          = step ? '0 : pre_q + PreW'(1);
    cnt_d          = cnt_q;
    if (step) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + WIDTH'(1);
    end
    period_start_d = step && (cnt_q == '0);
  end

  // Comparators and shadow writes; an out-of-range duty_sel matches no channel.
  always_comb begin
    led_d    = '0;
    shadow_d = shadow_q;
    for (int i = 0; i < CH; i++) begin
      led_d[i] = (cnt_q < active_q[i]);
      if (duty_we && (duty_sel == SELW'(i))) begin
        shadow_d[i] = duty_wdata;
      end
    end
  end

`ifdef PWM_BREATHE_EN
  localparam logic [WIDTH:0] StepW = (WIDTH + 1)'(STEP);

  logic [CH-1:0]         down_q, down_d;
  logic [CH-1:0][WIDTH:0] breathe_nxt;

  // Returns {down_next, active_next}; sums carry one extra bit so nothing wraps.
  function automatic logic [WIDTH:0] breathe_next(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] peak,
                                                  input logic             down);
    logic [WIDTH:0] cur_w, peak_w, sum_w, res;
    cur_w  = {1'b0, cur};
    peak_w = {1'b0, peak};
    sum_w  = cur_w + StepW;
    if (cur_w > peak_w) begin
      res = {1'b1, peak};
    end else if (!down) begin
      res = (sum_w >= peak_w) ? {1'b1, peak} : {1'b0, sum_w[WIDTH-1:0]};
    end else begin
      res = (cur_w <= StepW) ? {1'b0, WIDTH'(0)} : {1'b0, cur - StepW[WIDTH-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    active_d    = active_q;
    down_d      = down_q;
    breathe_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      breathe_nxt[i] = breathe_next(active_q[i], shadow_q[i], down_q[i]);
      if (boundary) begin
        if (breathe_en[i]) begin
          active_d[i] = breathe_nxt[i][WIDTH-1:0];
          down_d[i]   = breathe_nxt[i][WIDTH];
        end else begin
          // Leaving breathing mode: plain load, and the next ramp restarts upward.
          active_d[i] = shadow_q[i];
          down_d[i]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_q <= '0;
    end else begin
      down_q <= down_d;
    end
  end
`else
  localparam int unsigned UnusedStep = STEP;
  logic unused_breathe_en;
  assign unused_breathe_en = ^breathe_en;

  always_comb begin
    active_d = active_q;
    if (boundary) begin
      active_d = shadow_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      led_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_led_array.sv
// Bench for pwm_led_array: two instances (CH=4/PRESC=1 and CH=3/PRESC=4, WIDTH=4, STEP=3)
// checked against a period-arithmetic reference model plus directed duty/period counts.
module tb_pwm_led_array;

  logic       clk, rst, duty_we;
  logic [1:0] duty_sel;
  logic [3:0] duty_wdata;
  logic [3:0] breathe_a, led_a;
  logic [2:0] breathe_b, led_b;
  logic       ps_a, ps_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int         pos  [2];
  int         sh   [2][4];
  int         act  [2][4];
  bit         down [2][4];
  logic [3:0] eled [2];
  logic       eps  [2];
  logic [8:0] mdl_exp;
  wire  [8:0] dut_obs = {led_a, ps_a, led_b, ps_b};

  pwm_led_array #(.WIDTH(4), .CH(4), .PRESC(1), .STEP(3)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .duty_we      (duty_we),
    .duty_sel     (duty_sel),
    .duty_wdata   (duty_wdata),
    .breathe_en   (breathe_a),
    .led          (led_a),
    .period_start (ps_a)
  );

  pwm_led_array #(.WIDTH(4), .CH(3), .PRESC(4), .STEP(3)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .duty_we      (duty_we),
    .duty_sel     (duty_sel),
    .duty_wdata   (duty_wdata),
    .breathe_en   (breathe_b),
    .led          (led_b),
    .period_start (ps_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Position since reset gives the step count; cnt = step mod 15, period ends at cnt 14.
  task automatic model_step();
    int nch, p, cnt, pk;
    bit stp, bnd, be;
    for (int d = 0; d < 2; d++) begin
      nch = (d == 0) ? 4 : 3;
      p   = (d == 0) ? 1 : 4;
      if (rst) begin
        pos[d]  = 0;
        eps[d]  = 1'b0;
        eled[d] = '0;
        for (int i = 0; i < 4; i++) begin
          sh[d][i]   = 0;
          act[d][i]  = 0;
          down[d][i] = 1'b0;
        end
      end else begin
        cnt = (pos[d] / p) % 15;
        stp = ((pos[d] % p) == p - 1);
        bnd = stp && (cnt == 14);
        for (int i = 0; i < nch; i++) eled[d][i] = (cnt < act[d][i]);
        eps[d] = stp && (cnt == 0);
        if (bnd) begin
          for (int i = 0; i < nch; i++) begin
            if (d == 0) be = breathe_a[i];
            else        be = breathe_b[i];
`ifdef PWM_BREATHE_EN
            pk = sh[d][i];
            if (!be) begin
              act[d][i]  = pk;
              down[d][i] = 1'b0;
            end else if (act[d][i] > pk) begin
              act[d][i]  = pk;
              down[d][i] = 1'b1;
            end else if (!down[d][i]) begin
              if (act[d][i] + 3 >= pk) begin
                act[d][i]  = pk;
                down[d][i] = 1'b1;
              end else begin
                act[d][i] = act[d][i] + 3;
              end
            end else begin
              if (act[d][i] <= 3) begin
                act[d][i]  = 0;
                down[d][i] = 1'b0;
              end else begin
                act[d][i] = act[d][i] - 3;
              end
            end
`else
            pk = 0;
            be = be;
            act[d][i] = sh[d][i];
`endif
          end
        end
        if (duty_we && (int'(duty_sel) < nch)) sh[d][duty_sel] = int'(duty_wdata);
        pos[d]++;
      end
    end
    mdl_exp = {eled[0], eps[0], eled[1][2:0], eps[1]};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "bench timeout");
  end

  task automatic drive(input bit we, input int sel, input int val);
    duty_we    = we;
    duty_sel   = 2'(sel);
    duty_wdata = 4'(val);
  endtask

  task automatic wait_ps_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (ps_a === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    breathe_a = '0;
    breathe_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_obs !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", dut_obs, 9'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_reset t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
      if (k == 1) begin
        checks++;
        if (ps_a !== 1'b1) begin
          failures++;
          $display("FAIL reset_ps_a_first got=%b exp=1", ps_a);
        end
      end
      if (k == 4) begin
        checks++;
        if (ps_b !== 1'b1) begin
          failures++;
          $display("FAIL reset_ps_b_presc got=%b exp=1", ps_b);
        end
      end
    end
  endtask

  task automatic test_static_levels();
    for (int k = 0; k < 47; k++) begin
      if (k == 0) drive(1, 0, 0);
      else if (k == 1) drive(1, 1, 15);
      else drive(0, 0, 0);
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_static t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
      if (k >= 32) begin
        checks++;
        if (led_a[1:0] !== 2'b10) begin
          failures++;
          $display("FAIL static_levels t=%0t got=%b exp=10", $time, led_a[1:0]);
        end
      end
    end
  endtask

  task automatic test_duty_period();
    bit ok;
    int highs, extra;
    drive(1, 2, 5);
    @(negedge clk);
    drive(0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      wait_ps_a(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL duty_wait_ps got=timeout exp=period_start");
      end
    end
    highs = 0;
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      highs += int'(led_a[2]);
      if (k > 0 && ps_a === 1'b1) extra++;
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_duty t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
    end
    checks++;
    if (highs != 5) begin
      failures++;
      $display("FAIL duty5_highs got=%0d exp=5", highs);
    end
    checks++;
    if (ps_a !== 1'b1 || extra != 0) begin
      failures++;
      $display("FAIL ps_interval got=ps%b/extra%0d exp=ps1/extra0", ps_a, extra);
    end
  endtask

  task automatic test_midperiod_write();
    bit ok;
    int h1, h2;
    wait_ps_a(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_wait_ps got=timeout exp=period_start");
    end
    h1 = 0;
    h2 = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 15) h1 += int'(led_a[2]);
      else        h2 += int'(led_a[2]);
      if (k == 6) drive(1, 2, 10);
      if (k == 7) drive(0, 0, 0);
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_mid t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
    end
    checks++;
    if (h1 != 5 || h2 != 10) begin
      failures++;
      $display("FAIL mid_write_highs got=%0d,%0d exp=5,10", h1, h2);
    end
  endtask

  task automatic test_reset_midperiod();
    bit ok;
    wait_ps_a(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_wait_ps got=timeout exp=period_start");
    end
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_obs !== 9'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b exp=%b", dut_obs, 9'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ps_a !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ps got=%b exp=1", ps_a);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp || led_a !== 4'b0) begin
        failures++;
        $display("FAIL rstmid_cleared t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
    end
  endtask

  task automatic test_invalid_sel();
    int nz, last;
    drive(1, 3, 7);
    @(negedge clk);
    drive(0, 0, 0);
    nz   = 0;
    last = -1;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_badsel t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
      if (led_b !== 3'b0) nz++;
      if (ps_b === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (k - last != 60) begin
            failures++;
            $display("FAIL presc_period got=%0d exp=60", k - last);
          end
        end
        last = k;
      end
    end
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL badsel_ignored got=%0d exp=0", nz);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        breathe_a = 4'($urandom);
        breathe_b = 3'($urandom);
      end
      @(negedge clk);
      checks++;
      if (dut_obs !== mdl_exp) begin
        failures++;
        $display("FAIL model_random t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
      end
    end
    drive(0, 0, 0);
  endtask

  task automatic test_breathe();
    int exp_act [8];
    int highs, pss;
`ifdef PWM_BREATHE_EN
    exp_act = '{0, 3, 6, 9, 6, 3, 0, 3};
`else
    exp_act = '{0, 9, 9, 9, 9, 9, 9, 9};
`endif
    rst       = 1'b1;
    drive(0, 0, 0);
    breathe_a = '0;
    breathe_b = '0;
    @(negedge clk);
    rst       = 1'b0;
    breathe_b = 3'b001;
    drive(1, 0, 9);
    for (int n = 0; n < 8; n++) begin
      highs = 0;
      pss   = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        drive(0, 0, 0);
        checks++;
        if (dut_obs !== mdl_exp) begin
          failures++;
          $display("FAIL model_breathe t=%0t got=%b exp=%b", $time, dut_obs, mdl_exp);
        end
        highs += int'(led_b[0]);
        pss   += int'(ps_b);
      end
      checks++;
      if (highs != exp_act[n] * 4 || pss != 1) begin
        failures++;
        $display("FAIL breathe_period%0d got=%0d/ps%0d exp=%0d/ps1", n, highs, pss, exp_act[n] * 4);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    duty_we   = 1'b0;
    duty_sel  = '0;
    duty_wdata = '0;
    breathe_a = '0;
    breathe_b = '0;
    test_reset();
    test_static_levels();
    test_duty_period();
    test_midperiod_write();
    test_reset_midperiod();
    test_invalid_sel();
    test_random();
    test_breathe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
